// File: rtl/shift_transmitter_pkg.sv
// rtl/shift_transmitter_pkg.sv - shared state encodings and width constants for the serial transmitter
package shift_transmitter_pkg;

  // Word width used when the instantiating design does not override it.
  localparam int DEFAULT_DATA_WIDTH = 16;

  // Transmitter FSM encodings; also seen by anything decoding state in a debug view.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to hold a count from 0 up to and including the word width.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_transmitter_bit_counter.sv
// rtl/shift_transmitter_bit_counter.sv - loadable down-counter of remaining bits with zero and last flags
module bit_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             last
);

  // Count register: load wins over decrement, and it saturates at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  // Flags decoded purely from the register so they carry no input-to-output path.
  always_comb begin
    zero = (count == '0);
    last = (count == WIDTH'(1));
  end

endmodule

// File: rtl/shift_transmitter.sv
// rtl/shift_transmitter.sv - parallel-in serial-out transmitter with per-bit strobe and receiver back-pressure
module shift_transmitter
  import shift_transmitter_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  msb_first,
  input  logic                  pause,
  output logic                  ser_out,
  output logic                  ser_strb,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = count_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH);

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  msb_q;
  logic                  strb_q;
  logic                  accept;
  logic                  consume;
  logic                  finish;
  logic [CNT_W-1:0]      cnt;
  logic                  cnt_zero;
  logic                  cnt_last;

  // Handshake qualifiers. pause is registered through strb_q, so it gates the
  // strobe of the cycle after it is sampled and never reaches an output directly.
  always_comb begin
    accept  = (state == IDLE) && start;
    consume = (state == SHIFT) && strb_q;
    finish  = consume && cnt_last;
  end

  bit_counter #(
    .WIDTH (CNT_W)
  ) u_bit_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .load_value (CNT_LOAD),
    .dec        (consume),
    .count      (cnt),
    .zero       (cnt_zero),
    .last       (cnt_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; the zero check keeps SHIFT from stalling if the count is ever empty.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (finish || cnt_zero) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Word and bit order captured at acceptance; one place shifted out, zero filled, per strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      msb_q <= 1'b0;
    end else if (accept) begin
      shreg <= data_in;
      msb_q <= msb_first;
    end else if (consume) begin
      if (msb_q) begin
        shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
      end else begin
        shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
      end
    end
  end

  // Strobe enable for the next cycle: the first bit always goes out right after
  // acceptance, later bits only when the receiver was not pausing at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      strb_q <= 1'b0;
    end else if (accept) begin
      strb_q <= 1'b1;
    end else if ((state == SHIFT) && !finish && !cnt_zero) begin
      strb_q <= !pause;
    end else begin
      strb_q <= 1'b0;
    end
  end

  // Outputs decoded from state and registers only; the pending bit stays on ser_out while paused.
  always_comb begin
    ser_strb = 1'b0;
    ser_out  = 1'b0;
    busy     = (state != IDLE);
    done     = (state == DONE);
    if (state == SHIFT) begin
      ser_strb = strb_q;
      ser_out  = msb_q ? shreg[DATA_WIDTH-1] : shreg[0];
    end
  end

endmodule

// File: tb/tb_shift_transmitter.sv
// tb/tb_shift_transmitter.sv - self-checking bench for shift_transmitter against a bit-index reference model
module tb_shift_transmitter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] data_in;
  logic         msb_first;
  logic         pause;
  logic         ser_out;
  logic         ser_strb;
  logic         busy;
  logic         done;

  shift_transmitter #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .msb_first (msb_first),
    .pause     (pause),
    .ser_out   (ser_out),
    .ser_strb  (ser_strb),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference model: a transfer is the word plus how many of its bits have gone out.
  logic         m_active = 1'b0;
  logic         m_strb = 1'b0;
  logic         m_done = 1'b0;
  int           m_sent = 0;
  logic [W-1:0] m_word = '0;
  logic         m_msb = 1'b0;

  // Advance the model on each edge from the inputs the DUT sees.
  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0; m_strb = 1'b0; m_done = 1'b0; m_sent = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1; m_word = data_in; m_msb = msb_first; m_sent = 0; m_strb = 1'b1;
      end
    end else begin
      if (m_strb) m_sent = m_sent + 1;
      if (m_sent >= W) begin
        m_active = 1'b0; m_strb = 1'b0; m_done = 1'b1;
      end else begin
        m_strb = !pause;
      end
    end
  end

  int           pass_cnt = 0;
  int           total_cnt = 0;
  int           cyc, nstrb, busy_cnt, done_cnt, done_cyc;
  logic [W-1:0] bits, rx;
  logic         rx_msb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act !== req) $display("FAIL %s actual=%0h required=%0h", name, act, req);
    else pass_cnt++;
  endtask

  // One cycle: compare against the model away from the edge, then collect stream statistics.
  task automatic tick();
    logic e_out;
    logic e_busy;
    @(negedge clk);
    cyc++;
    e_out  = (m_active && m_sent < W) ? (m_msb ? m_word[W-1-m_sent] : m_word[m_sent]) : 1'b0;
    e_busy = m_active || m_done;
    total_cnt++;
    if ({ser_out, ser_strb, busy, done} !== {e_out, m_strb, e_busy, m_done})
      $display("FAIL cycle_model t=%0t actual out/strb/busy/done=%b%b%b%b required=%b%b%b%b",
               $time, ser_out, ser_strb, busy, done, e_out, m_strb, e_busy, m_done);
    else pass_cnt++;
    if (ser_strb === 1'b1) begin
      if (nstrb < W) bits[nstrb] = ser_out;
      nstrb++;
      if (rx_msb) rx = {rx[W-2:0], ser_out};
      else        rx = {ser_out, rx[W-1:1]};
    end
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
  endtask

  task automatic clear_stats();
    cyc = 1; nstrb = 0; busy_cnt = 0; done_cnt = 0; done_cyc = 0; bits = '0; rx = '0;
  endtask

  // Present a start for one cycle; the start cycle itself is cycle 1.
  task automatic start_xfer(input logic [W-1:0] word, input logic msb);
    data_in = word; msb_first = msb; rx_msb = msb; start = 1'b1;
    clear_stats();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin tick(); n++; end
    check("done_seen_in_budget", 32'(done_cnt != 0), 32'd1);
  endtask

  initial begin
    int hold;
    logic fired;
    rst = 1'b1; start = 1'b0; data_in = '0; msb_first = 1'b0; pause = 1'b0; rx_msb = 1'b0;
    clear_stats();
    tick(); tick();
    check("reset_ser_out", 32'(ser_out), 32'd0);
    check("reset_ser_strb", 32'(ser_strb), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // A5C3 LSB first.
    start_xfer(16'hA5C3, 1'b0);
    wait_done(40);
    check("lsb_bits", 32'(bits), 32'h0000A5C3);
    check("lsb_strobes", 32'(nstrb), 32'd16);
    check("lsb_rx", 32'(rx), 32'h0000A5C3);
    check("lsb_busy_cycles", 32'(busy_cnt), 32'd17);
    check("lsb_done_cycle", 32'(done_cyc), 32'd18);
    tick();

    // A5C3 MSB first: stream order is the bit reverse of the LSB case.
    start_xfer(16'hA5C3, 1'b1);
    wait_done(40);
    check("msb_bits", 32'(bits), 32'h0000C3A5);
    check("msb_rx", 32'(rx), 32'h0000A5C3);
    tick();

    // 8001 LSB first with three paused cycles after the fifth strobe.
    start_xfer(16'h8001, 1'b0);
    hold = 0; fired = 1'b0;
    for (int n = 0; n < 60 && done_cnt == 0; n++) begin
      tick();
      if (nstrb == 5 && !fired) begin
        pause = 1'b1; hold = 3; fired = 1'b1;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) pause = 1'b0;
      end
    end
    pause = 1'b0;
    check("pause_done_seen", 32'(done_cnt), 32'd1);
    check("pause_strobes", 32'(nstrb), 32'd16);
    check("pause_shift_cycles", 32'(busy_cnt - done_cnt), 32'd19);
    check("pause_done_cycle", 32'(done_cyc), 32'd21);
    check("pause_rx", 32'(rx), 32'h00008001);
    tick();

    // start with FFFF during bits 2..4 of a 0000 transfer is ignored.
    start_xfer(16'h0000, 1'b0);
    hold = 0; fired = 1'b0;
    for (int n = 0; n < 40 && done_cnt == 0; n++) begin
      tick();
      if (nstrb == 2 && !fired) begin
        start = 1'b1; data_in = 16'hFFFF; hold = 3; fired = 1'b1;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) start = 1'b0;
      end
    end
    start = 1'b0;
    check("ignore_bits", 32'(bits), 32'd0);
    check("ignore_strobes", 32'(nstrb), 32'd16);
    check("ignore_busy_cycles", 32'(busy_cnt), 32'd17);
    tick();

    // Reset after the seventh strobe aborts; a start right after release is accepted.
    start_xfer(16'h5A5A, 1'b0);
    for (int n = 0; n < 30 && nstrb < 7; n++) tick();
    check("abort_strobes_before_rst", 32'(nstrb), 32'd7);
    rst = 1'b1;
    tick();
    check("abort_ser_out", 32'(ser_out), 32'd0);
    check("abort_ser_strb", 32'(ser_strb), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_no_done_pulse", 32'(done_cnt), 32'd0);
    rst = 1'b0;
    start_xfer(16'h0001, 1'b0);
    check("restart_accepted", 32'(busy), 32'd1);
    wait_done(40);
    check("restart_rx", 32'(rx), 32'h00000001);
    check("restart_strobes", 32'(nstrb), 32'd16);
    tick();

    // start during the done cycle is dropped; held one more cycle it is accepted.
    start_xfer(16'h3C3C, 1'b1);
    wait_done(40);
    start = 1'b1; data_in = 16'h1234; msb_first = 1'b0;
    tick();
    check("start_in_done_ignored", 32'(busy), 32'd0);
    clear_stats();
    rx_msb = 1'b0;
    tick();
    start = 1'b0;
    check("start_after_done_accepted", 32'(busy), 32'd1);
    wait_done(40);
    check("after_done_rx", 32'(rx), 32'h00001234);
    tick();

    // start together with pause in IDLE: first strobe is not held back.
    pause = 1'b1;
    start_xfer(16'h00F0, 1'b1);
    check("start_with_pause_first_strobe", 32'(ser_strb), 32'd1);
    tick(); tick();
    pause = 1'b0;
    wait_done(40);
    check("start_with_pause_rx", 32'(rx), 32'h000000F0);
    tick();

    // Randomized traffic, pausing and occasional resets, checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      start     = ($urandom_range(0, 5) == 0);
      data_in   = W'($urandom);
      msb_first = $urandom_range(0, 1) == 1;
      pause     = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 249) == 0);
      tick();
    end
    rst = 1'b0; start = 1'b0; pause = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/shift_transmitter.md
SHIFT_TRANSMITTER -- requirements
Module: shift_transmitter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, giving the word width in bits (minimum 2).
REQ-002 SHALL have input clk, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 SHALL have input rst, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have input start, 1 bit, a request to transmit data_in.
REQ-005 SHALL have input data_in, DATA_WIDTH bits, the word sampled when start is accepted.
REQ-006 SHALL have input msb_first, 1 bit, sampled with data_in: 0 = LSB first (receiver uses right shift), 1 = MSB first (receiver uses left shift).
REQ-007 SHALL have input pause, 1 bit, a receiver back-pressure input that stalls shifting.
REQ-008 SHALL have output ser_out, 1 bit, the current serial data bit.
REQ-009 SHALL have output ser_strb, 1 bit, high for exactly one cycle per valid bit; the receiver shifts on it.
REQ-010 SHALL have output busy, 1 bit, high from the cycle after acceptance until the done cycle inclusive.
REQ-011 SHALL have output done, 1 bit, a one-cycle pulse after the last bit.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-013 In IDLE, start=1 SHALL capture data_in and msb_first into an internal shift register, load the bit counter with DATA_WIDTH, and move to SHIFT on the next edge.
REQ-014 In SHIFT with pause=0: ser_strb=1, ser_out = bit 0 (LSB-first) or bit DATA_WIDTH-1 (MSB-first); at the edge, shift one place (zero fill) and decrement the counter.
REQ-015 In SHIFT with pause=1: ser_strb=0, ser_out holds the pending bit, and the shift register and counter hold.
REQ-016 When the counter reaches 0 after the last strobe, the FSM SHALL move to DONE; DONE asserts done=1 for one cycle, then returns to IDLE.
REQ-017 Latency from the start edge to the first strobe SHALL be 1 cycle; with pause=0, exactly DATA_WIDTH consecutive strobes SHALL occur, then done in the next cycle.
REQ-018 start outside IDLE, including in DONE, SHALL be ignored, with no queuing.
REQ-019 start and pause both high in IDLE: start SHALL be accepted, and pause acts only from SHIFT onward.
REQ-020 In IDLE and DONE, ser_strb SHALL be 0 and ser_out SHALL be 0.
REQ-021 The counter SHALL be $clog2(DATA_WIDTH+1) bits wide and SHALL never wrap below 0.
REQ-022 All outputs SHALL be registered or derived only from state and registers, with no combinational path from any input to any output.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, clear the shift register and counter, and set ser_out=0, ser_strb=0, busy=0, done=0.
REQ-024 rst SHALL take priority over start and pause.
REQ-025 rst in the middle of a transfer SHALL abort it with no done pulse, and the block SHALL accept start in the first cycle after rst is released.

Structure
REQ-026 State encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default width constant SHALL live in the shared project package or include file.
REQ-027 One sub-module, bit_counter (loadable down-counter with a zero flag), SHALL be used; everything else SHALL be in shift_transmitter.

Verification
REQ-028 Send 16'hA5C3 LSB-first with pause=0: ser_out on strobes SHALL be 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, and a right-shift receiver SHALL end at 16'hA5C3.
REQ-029 Send 16'hA5C3 MSB-first: ser_out SHALL be 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1, and a left-shift receiver SHALL end at 16'hA5C3.
REQ-030 Send 16'h8001 LSB-first with pause high for 3 cycles after the 5th strobe: SHALL produce 16 strobes over 19 SHIFT cycles, ser_out held during pause, and done on cycle 21 after start.
REQ-031 Pulse start=1 with data_in=16'hFFFF during bits 2..4 of an ongoing 16'h0000 transfer: the serial stream SHALL remain all zeros and busy SHALL stay high for 17 cycles.
REQ-032 Assert rst after the 7th strobe: all outputs SHALL be 0 next cycle with no done pulse; a new start of 16'h0001 SHALL then complete normally.
REQ-033 Drive start=1 in the same cycle as done: it SHALL be ignored, and start the following cycle SHALL be accepted.
